uart_recv: RTL and testbench

Oversampling UART receiver: the receive-side counterpart of the team's `uart_send` transmitter. It runs entirely on `clk_sample` at OVERSAMPLE times the line baud rate. It recovers 8N1 frames (LSB first) from the asynchronous `rxd` pin and presents each byte in a one-entry holding register. The host acknowledges through the active-low read strobe `rdn`, which uses the same synchronised falling-edge handshake as `wrn` on the transmit side.

---
 rtl/uart_recv.sv | 168 ++++++++++++++++
 tb/tb_uart_recv.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// uart_recv: oversampling 8N1 UART receiver running on clk_sample.
// Recovers LSB-first frames from the asynchronous rxd pin, samples each bit
// at its centre and presents completed bytes in a one-entry holding register
// acknowledged by the falling edge of the active-low read strobe rdn.
`timescale 1ns/1ps

module uart_recv #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_sample,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rdn,
   output logic [7:0] dout,
   output logic       rdy,
   output logic       overrun,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      START   = 5'b00010,
      DATA    = 5'b00100,
      STOP    = 5'b01000,
      RECOVER = 5'b10000
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bitn, bitn_nxt;
   logic [7:0]       shift_reg, shift_nxt;
   logic             rxd1, rxd2;
   logic             rdn1, rdn2;
   logic             rd_edge;
   logic             byte_done;
   logic             stop_bad;

   // Two-flop synchronisers for the asynchronous line and read strobe (idle high)
   always_ff @(posedge clk_sample or negedge rst) begin
      if (!rst) begin
         rxd1 <= 1'b1;
         rxd2 <= 1'b1;
         rdn1 <= 1'b1;
         rdn2 <= 1'b1;
      end else begin
         rxd1 <= rxd;
         rxd2 <= rxd1;
         rdn1 <= rdn;
         rdn2 <= rdn1;
      end
   end

   // A read is the synchronised falling edge of rdn
   assign rd_edge = !rdn1 && rdn2;

   // Receiver state, tick/bit counters and the shift register
   always_ff @(posedge clk_sample or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bitn      <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bitn      <= bitn_nxt;
         shift_reg <= shift_nxt;
      end
   end

   // Frame sequencing: half-bit into the start bit, then one full bit per sample
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bitn_nxt  = bitn;
      shift_nxt = shift_reg;
      byte_done = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!rxd2) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         START: begin
            if (cnt == CNT_MID) begin
               cnt_nxt = '0;
               if (!rxd2) begin
                  state_nxt = DATA;
                  bitn_nxt  = '0;
               end else begin
                  // Line went back high before mid start bit: treat as a glitch
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               shift_nxt = {rxd2, shift_reg[7:1]};
               cnt_nxt   = '0;
               bitn_nxt  = bitn + 3'd1;
               if (bitn == 3'd7) begin
                  state_nxt = STOP;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (rxd2) begin
                  byte_done = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = RECOVER;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RECOVER: begin
            // Only a high line re-arms reception, so a break never starts a frame
            if (rxd2) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            bitn_nxt  = '0;
         end
      endcase
   end

   // Holding register: a completed byte wins over a simultaneous read
   always_ff @(posedge clk_sample or negedge rst) begin
      if (!rst) begin
         dout      <= 8'h00;
         rdy       <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         if (byte_done) begin
            dout <= shift_reg;
            rdy  <= 1'b1;
            if (rd_edge) begin
               overrun <= 1'b0;
            end else if (rdy) begin
               overrun <= 1'b1;
            end
         end else if (rd_edge) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed and randomized frames against a frame-level model
// of the receiver's holding register.
`timescale 1ns/1ps

module tb_uart_recv;

   localparam int N      = 16;
   localparam int STOP_C = 2 + N / 2 + 9 * N;   // stop-bit sample edge index (154)
   localparam int RST_C  = 5 * N + 8;           // middle of data bit 4

   logic       clk_sample = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       rdn = 1'b1;
   logic [7:0] dout;
   logic       rdy, overrun, frame_err;

   int n_pass  = 0;
   int n_total = 0;
   int fe_cnt  = 0;

   // observations captured by the drivers
   logic       pre_rdy, pre_fe;
   logic       post_rdy, post_ovr, post_fe;
   logic [7:0] post_dout;
   logic       rst_rdy, rst_ovr, rst_fe;
   logic [7:0] rst_dout;
   logic       rd_mid_rdy, rd_post_rdy, rd_post_ovr;

   uart_recv #(.OVERSAMPLE(N)) dut (
      .clk_sample (clk_sample),
      .rst        (rst),
      .rxd        (rxd),
      .rdn        (rdn),
      .dout       (dout),
      .rdy        (rdy),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 clk_sample = ~clk_sample;

   always @(negedge clk_sample) begin
      if (frame_err === 1'b1) fe_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sample);
      #1;
   endtask

   // Drives one 8N1 frame; c counts pin cycles from the start-bit edge E0
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_fall, input int rst_at);
      int bi;
      for (int c = 0; c < 10 * N; c++) begin
         bi = c / N;
         if (bi == 0) rxd = 1'b0;
         else if (bi <= 8) rxd = b[bi-1];
         else rxd = stop;
         if (c == rd_fall) rdn = 1'b0;
         if (c == rd_fall + 1) rdn = 1'b1;
         if (c == rst_at) begin
            rst = 1'b0;
            #1;
            rst_rdy  = rdy;
            rst_dout = dout;
            rst_ovr  = overrun;
            rst_fe   = frame_err;
         end
         if (c == rst_at + 2) rst = 1'b1;
         if (c == STOP_C) begin
            pre_rdy = rdy;
            pre_fe  = frame_err;
         end
         tick(1);
         if (c == STOP_C) begin
            post_rdy  = rdy;
            post_dout = dout;
            post_ovr  = overrun;
            post_fe   = frame_err;
         end
      end
   endtask

   // One-cycle rdn low pulse followed by the minimum high time
   task automatic do_read();
      rdn = 1'b0;
      tick(1);
      rd_mid_rdy = rdy;
      rdn = 1'b1;
      tick(1);
      rd_post_rdy = rdy;
      rd_post_ovr = overrun;
      tick(2);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) begin
         rxd = 1'($urandom_range(0, 1));
         tick(1);
         n_total++;
         if ({dout, rdy, overrun, frame_err} !== 11'h000)
            $display("FAIL reset_hold[%0d]: dout=%h rdy=%b ovr=%b fe=%b, required all zero", i, dout, rdy, overrun, frame_err);
         else n_pass++;
      end
      rxd = 1'b1;
      tick(2);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(5);
         n_total++;
         if ({dout, rdy, overrun, frame_err} !== 11'h000)
            $display("FAIL reset_after[%0d]: dout=%h rdy=%b ovr=%b fe=%b, required all zero", i, dout, rdy, overrun, frame_err);
         else n_pass++;
      end
      n_total++;
      if (fe_cnt !== 0) $display("FAIL reset_fe_count: got %0d, required 0", fe_cnt);
      else n_pass++;
   endtask

   task automatic test_single_byte();
      send_frame(8'h55, 1'b1, -1, -1);
      n_total++;
      if (pre_rdy !== 1'b0) $display("FAIL single_rdy_before_E154: got %b, required 0", pre_rdy);
      else n_pass++;
      n_total++;
      if (post_rdy !== 1'b1) $display("FAIL single_rdy_at_E154: got %b, required 1", post_rdy);
      else n_pass++;
      n_total++;
      if (post_dout !== 8'h55) $display("FAIL single_dout: got %h, required 55", post_dout);
      else n_pass++;
      n_total++;
      if (fe_cnt !== 0) $display("FAIL single_frame_err: got %0d pulses, required 0", fe_cnt);
      else n_pass++;
      do_read();
      n_total++;
      if (rd_mid_rdy !== 1'b1) $display("FAIL single_read_one_edge: rdy=%b, required 1", rd_mid_rdy);
      else n_pass++;
      n_total++;
      if (rd_post_rdy !== 1'b0) $display("FAIL single_read_two_edges: rdy=%b, required 0", rd_post_rdy);
      else n_pass++;
   endtask

   task automatic test_glitch();
      int fe0;
      fe0 = fe_cnt;
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      tick(40);
      n_total++;
      if (rdy !== 1'b0 || fe_cnt !== fe0)
         $display("FAIL glitch_ignored: rdy=%b fe_pulses=%0d, required rdy=0 fe_pulses=%0d", rdy, fe_cnt, fe0);
      else n_pass++;
      send_frame(8'hA3, 1'b1, -1, -1);
      n_total++;
      if (post_rdy !== 1'b1 || post_dout !== 8'hA3)
         $display("FAIL glitch_next_byte: rdy=%b dout=%h, required rdy=1 dout=a3", post_rdy, post_dout);
      else n_pass++;
   endtask

   task automatic test_framing_error();
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, -1, -1);
      n_total++;
      if (pre_fe !== 1'b0 || post_fe !== 1'b1)
         $display("FAIL ferr_pulse_edge: before=%b at_E154=%b, required 0 then 1", pre_fe, post_fe);
      else n_pass++;
      n_total++;
      if (post_rdy !== 1'b1 || post_dout !== 8'hA3)
         $display("FAIL ferr_hold_kept: rdy=%b dout=%h, required rdy=1 dout=a3", post_rdy, post_dout);
      else n_pass++;
      tick(40);
      rxd = 1'b1;
      tick(160);
      n_total++;
      if (fe_cnt !== fe0 + 1) $display("FAIL ferr_single_pulse: got %0d pulses, required %0d", fe_cnt - fe0, 1);
      else n_pass++;
      n_total++;
      if (rdy !== 1'b1 || dout !== 8'hA3 || overrun !== 1'b0)
         $display("FAIL ferr_no_retrigger: rdy=%b dout=%h ovr=%b, required 1 a3 0", rdy, dout, overrun);
      else n_pass++;
      do_read();
      send_frame(8'h81, 1'b1, -1, -1);
      n_total++;
      if (post_rdy !== 1'b1 || post_dout !== 8'h81 || post_ovr !== 1'b0)
         $display("FAIL ferr_next_byte: rdy=%b dout=%h ovr=%b, required 1 81 0", post_rdy, post_dout, post_ovr);
      else n_pass++;
   endtask

   task automatic test_overrun();
      do_read();
      send_frame(8'h12, 1'b1, -1, -1);
      n_total++;
      if (post_ovr !== 1'b0 || post_dout !== 8'h12)
         $display("FAIL ovr_first: ovr=%b dout=%h, required 0 12", post_ovr, post_dout);
      else n_pass++;
      send_frame(8'h34, 1'b1, -1, -1);
      n_total++;
      if (post_ovr !== 1'b1 || post_dout !== 8'h34 || post_rdy !== 1'b1)
         $display("FAIL ovr_second: ovr=%b dout=%h rdy=%b, required 1 34 1", post_ovr, post_dout, post_rdy);
      else n_pass++;
      rxd = 1'b1;
      tick(2);
      do_read();
      n_total++;
      if (rd_post_rdy !== 1'b0 || rd_post_ovr !== 1'b0)
         $display("FAIL ovr_cleared: rdy=%b ovr=%b, required 0 0", rd_post_rdy, rd_post_ovr);
      else n_pass++;
   endtask

   task automatic test_back_to_back_read();
      send_frame(8'h66, 1'b1, -1, -1);
      send_frame(8'h77, 1'b1, STOP_C - 1, -1);
      n_total++;
      if (pre_rdy !== 1'b1) $display("FAIL simul_prev_unread: rdy=%b, required 1", pre_rdy);
      else n_pass++;
      n_total++;
      if (post_rdy !== 1'b1 || post_dout !== 8'h77 || post_ovr !== 1'b0)
         $display("FAIL simul_read: rdy=%b dout=%h ovr=%b, required 1 77 0", post_rdy, post_dout, post_ovr);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'hF0, 1'b1, -1, RST_C);
      n_total++;
      if ({rst_dout, rst_rdy, rst_ovr, rst_fe} !== 11'h000)
         $display("FAIL midrst_immediate: dout=%h rdy=%b ovr=%b fe=%b, required all zero", rst_dout, rst_rdy, rst_ovr, rst_fe);
      else n_pass++;
      n_total++;
      if (post_rdy !== 1'b0 || rdy !== 1'b0 || dout !== 8'h00 || fe_cnt !== fe0)
         $display("FAIL midrst_no_byte: rdy=%b dout=%h fe_pulses=%0d, required 0 00 0", rdy, dout, fe_cnt - fe0);
      else n_pass++;
      send_frame(8'h0F, 1'b1, -1, -1);
      n_total++;
      if (post_rdy !== 1'b1 || post_dout !== 8'h0F || post_ovr !== 1'b0)
         $display("FAIL midrst_next_byte: rdy=%b dout=%h ovr=%b, required 1 0f 0", post_rdy, post_dout, post_ovr);
      else n_pass++;
   endtask

   // Random frames, gaps, bad stop bits and reads against a holding-register model
   task automatic test_random();
      logic [7:0] m_dout, b;
      logic       m_rdy, m_ovr, stop, bad_prev, exp_pre;
      int         gap, rd;
      m_dout   = 8'h0F;
      m_rdy    = 1'b1;
      m_ovr    = 1'b0;
      bad_prev = 1'b0;
      for (int it = 0; it < 14; it++) begin
         rxd = 1'b1;
         if ($urandom_range(0, 2) == 0) begin
            do_read();
            m_rdy = 1'b0;
            m_ovr = 1'b0;
            n_total++;
            if (rd_post_rdy !== 1'b0 || rd_post_ovr !== 1'b0)
               $display("FAIL rand_read[%0d]: rdy=%b ovr=%b, required 0 0", it, rd_post_rdy, rd_post_ovr);
            else n_pass++;
         end
         if (bad_prev) gap = $urandom_range(8, 30);
         else gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30);
         if (gap > 0) tick(gap);
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         rd   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, STOP_C - 1) : -1;
         if (rd >= 0 && rd < STOP_C - 1) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
         end
         exp_pre = m_rdy;
         send_frame(b, stop, rd, -1);
         if (stop) begin
            if (rd == STOP_C - 1) m_ovr = 1'b0;
            else if (m_rdy) m_ovr = 1'b1;
            m_rdy  = 1'b1;
            m_dout = b;
         end else if (rd == STOP_C - 1) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
         end
         n_total++;
         if (pre_rdy !== exp_pre)
            $display("FAIL rand_pre_rdy[%0d]: got %b, required %b", it, pre_rdy, exp_pre);
         else n_pass++;
         n_total++;
         if (post_rdy !== m_rdy || post_dout !== m_dout || post_ovr !== m_ovr)
            $display("FAIL rand_frame[%0d]: rdy=%b dout=%h ovr=%b, required %b %h %b (byte %h stop %b rd %0d)",
                     it, post_rdy, post_dout, post_ovr, m_rdy, m_dout, m_ovr, b, stop, rd);
         else n_pass++;
         n_total++;
         if (post_fe !== !stop)
            $display("FAIL rand_ferr[%0d]: got %b, required %b", it, post_fe, !stop);
         else n_pass++;
         bad_prev = !stop;
      end
      rxd = 1'b1;
      tick(20);
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_framing_error();
      test_overrun();
      test_back_to_back_read();
      test_reset_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
